// File: rtl/wiener_block_feeder_if.sv
// Bus bundle between the Wiener block feeder and its environment: frame request,
// 1-cycle-latency memory read port, block pixel stream and block acknowledge.
interface wiener_block_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
);
  // Handshake semantics: frame_start is a 1-cycle request honoured only when busy is low.
  // mem_rd_en is a strobe and mem_rd_data is valid exactly one cycle later, with no stall.
  // data_valid has no ready: the stream cannot be back-pressured inside a block. Flow control
  // is per block only, because the feeder waits for one block_ack pulse before the next block.
  logic                  frame_start;
  logic [15:0]           frame_width;
  logic [15:0]           frame_height;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  block_ack;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  start_of_frame;
  logic                  start_of_block;
  logic                  end_of_frame;
  logic [31:0]           blocks_per_frame;
  logic                  busy;
  logic                  frame_done;
  logic                  dim_error;

  modport master (
    input  frame_start, frame_width, frame_height, base_addr, mem_rd_data, block_ack,
    output mem_rd_en, mem_addr, data_out, data_valid, start_of_frame, start_of_block,
           end_of_frame, blocks_per_frame, busy, frame_done, dim_error
  );

  modport slave (
    output frame_start, frame_width, frame_height, base_addr, mem_rd_data, block_ack,
    input  mem_rd_en, mem_addr, data_out, data_valid, start_of_frame, start_of_block,
           end_of_frame, blocks_per_frame, busy, frame_done, dim_error
  );
endinterface

// File: rtl/wiener_block_feeder.sv
// Frame-to-block serializer: reads a row-major frame and streams it block by block,
// pausing between blocks until the downstream statistics path acknowledges each block.
module wiener_block_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  wiener_block_feeder_if.master bus,
  output logic [1:0]            state_dbg
);

  localparam int                    LOG2B    = $clog2(BLOCK_SIZE);
  localparam logic [LOG2B-1:0]      IDX_LAST = LOG2B'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] B_STEP   = ADDR_WIDTH'(BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    WAIT_ACK   = 2'd2,
    FLUSH_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [15:0]           blk_x_last;
  logic [15:0]           blk_y_last;
  logic [15:0]           bx;
  logic [15:0]           by;
  logic [LOG2B-1:0]      col;
  logic [LOG2B-1:0]      row;
  logic [ADDR_WIDTH-1:0] width_a;
  logic [ADDR_WIDTH-1:0] width_blk;
  logic [ADDR_WIDTH-1:0] blk_row_addr;
  logic [ADDR_WIDTH-1:0] blk_addr;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic                  ack_pend;
  logic                  dv_q;
  logic                  sof_q;
  logic                  sob_q;
  logic                  eof_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dim_err_q;
  logic [31:0]           bpf_q;

  logic [15:0]           blocks_x;
  logic [15:0]           blocks_y;
  logic                  dims_ok;
  logic                  last_col;
  logic                  last_row;
  logic                  last_bx;
  logic                  last_block;
  logic                  rd_first;
  logic                  rd_sof;
  logic                  rd_eof;
  logic                  ack_now;
  logic [ADDR_WIDTH-1:0] nxt_blk_addr;
  logic [ADDR_WIDTH-1:0] nxt_blk_row_addr;

  assign blocks_x = bus.frame_width >> LOG2B;
  assign blocks_y = bus.frame_height >> LOG2B;
  assign dims_ok  = (bus.frame_width != 16'd0) && (bus.frame_height != 16'd0) &&
                    (bus.frame_width[LOG2B-1:0] == '0) && (bus.frame_height[LOG2B-1:0] == '0);

  assign last_col   = (col == IDX_LAST);
  assign last_row   = (row == IDX_LAST);
  assign last_bx    = (bx == blk_x_last);
  assign last_block = last_bx && (by == blk_y_last);
  assign ack_now    = bus.block_ack || ack_pend;

  // Flags travel with the read strobe and are delayed one cycle to line up with the data.
  assign rd_first = rd_en && (col == '0) && (row == '0);
  assign rd_sof   = rd_first && (bx == 16'd0) && (by == 16'd0);
  assign rd_eof   = rd_en && last_col && last_row && last_block;

  // Block origins advance by adding B along a block row, or one block-row stride at its end.
  always_comb begin
    nxt_blk_addr     = blk_addr + B_STEP;
    nxt_blk_row_addr = blk_row_addr;
    if (last_bx) begin
      nxt_blk_row_addr = blk_row_addr + width_blk;
      nxt_blk_addr     = blk_row_addr + width_blk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      blk_x_last   <= '0;
      blk_y_last   <= '0;
      bx           <= '0;
      by           <= '0;
      col          <= '0;
      row          <= '0;
      width_a      <= '0;
      width_blk    <= '0;
      blk_row_addr <= '0;
      blk_addr     <= '0;
      row_addr     <= '0;
      rd_addr      <= '0;
      rd_en        <= 1'b0;
      ack_pend     <= 1'b0;
      dv_q         <= 1'b0;
      sof_q        <= 1'b0;
      sob_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dim_err_q    <= 1'b0;
      bpf_q        <= '0;
    end else begin
      dim_err_q <= 1'b0;
      done_q    <= 1'b0;
      dv_q      <= rd_en;
      sof_q     <= rd_sof;
      sob_q     <= rd_first;
      eof_q     <= rd_eof;

      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            if (dims_ok) begin
              width_a      <= ADDR_WIDTH'(bus.frame_width);
              width_blk    <= ADDR_WIDTH'(bus.frame_width) << LOG2B;
              blk_x_last   <= blocks_x - 16'd1;
              blk_y_last   <= blocks_y - 16'd1;
              bpf_q        <= 32'(blocks_x) * 32'(blocks_y);
              bx           <= '0;
              by           <= '0;
              col          <= '0;
              row          <= '0;
              blk_row_addr <= bus.base_addr;
              blk_addr     <= bus.base_addr;
              row_addr     <= bus.base_addr;
              rd_addr      <= bus.base_addr;
              rd_en        <= 1'b1;
              ack_pend     <= 1'b0;
              busy_q       <= 1'b1;
              state        <= FETCH;
            end else begin
              dim_err_q <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (bus.block_ack) begin
            ack_pend <= 1'b1;
          end
          if (!last_col) begin
            col     <= col + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end else if (!last_row) begin
            col      <= '0;
            row      <= row + 1'b1;
            row_addr <= row_addr + width_a;
            rd_addr  <= row_addr + width_a;
          end else begin
            col   <= '0;
            row   <= '0;
            rd_en <= 1'b0;
            state <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (ack_now) begin
            ack_pend <= 1'b0;
            if (last_block) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= FLUSH_DONE;
            end else begin
              bx           <= last_bx ? 16'd0 : bx + 16'd1;
              by           <= last_bx ? by + 16'd1 : by;
              blk_addr     <= nxt_blk_addr;
              blk_row_addr <= nxt_blk_row_addr;
              row_addr     <= nxt_blk_addr;
              rd_addr      <= nxt_blk_addr;
              rd_en        <= 1'b1;
              state        <= FETCH;
            end
          end
        end

        FLUSH_DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_en        = rd_en;
  assign bus.mem_addr         = rd_addr;
  assign bus.data_valid       = dv_q;
  assign bus.data_out         = dv_q ? bus.mem_rd_data : '0;
  assign bus.start_of_frame   = sof_q;
  assign bus.start_of_block   = sob_q;
  assign bus.end_of_frame     = eof_q;
  assign bus.blocks_per_frame = bpf_q;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = done_q;
  assign bus.dim_error        = dim_err_q;
  assign state_dbg            = state;

endmodule
